vn_lut_update_ctrl: RTL
=======================

# vn_lut_update_ctrl

Sequencing controller for the symmetric VN lookup-table read/write block. It owns the LUT write port and reloads all 32 pages of both write replicates from a streamed table, for example the new IB mapping at an iteration boundary. Before any write, it drains in-flight reads so no VNU lookup sees a half-updated table. It also gates read requests from the two VNU read ports (A/B) while a reload is in progress.

## Interface
Parameters:
- DEPTH, 32, LUT pages per replicate.
- ADDR_W, 5, page address width (log2 DEPTH).
- DATA_W, 3, LUT entry width.
- RD_LAT, 3, LUT read latency in cycles, from request to `t_c` valid.

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  single clock; drives both the LUT read_clk and write_clk.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  single-cycle pulse requesting a table reload.
- upd_valid  in  1  an update entry is present on `upd_data`.
- upd_data  in  DATA_W  entry for the current page; entries arrive in page order 0..DEPTH-1.
- upd_ready  out  1  controller accepts an entry this cycle.
- rd_req_A / rd_req_B  in  1  VNU port A/B read request.
- rd_gnt_A / rd_gnt_B  out  1  read granted; the VNU may drive `y0_in`/`y1_in` this cycle.
- we  out  1  LUT write enable.
- page_write_addr_replicate_0 / _1  out  ADDR_W  write address; both replicates carry the same value.
- lut_in_bank0_replicate_0 / _1  out  DATA_W  write data; both replicates carry the same value.
- write_addr_offset_replicate_0 / _1  out  1  tied to 0 (deprecated field).
- busy  out  1  state is not IDLE.
- table_valid  out  1  the LUT holds a complete table.
- load_done  out  1  one-cycle pulse when a reload completes.
- lut_iter  out  4  count of completed reloads.
- load_overrun  out  1  sticky flag: a `load_req` arrived while busy.

## Operation
- States and transitions:
  - IDLE: goes to DRAIN when `load_req` = 1.
  - DRAIN: goes to WRITE when the in-flight counter `inflight` = 0.
  - WRITE: goes to DONE when the beat with `wr_cnt` = DEPTH-1 is accepted.
  - DONE: goes to IDLE unconditionally after one cycle.
- Read gating:
  - rd_gnt_X = rd_req_X & (state == IDLE) & ~load_req. The gating is combinational; `load_req` has priority over reads in the same cycle.
  - Ports A and B are independent; both may be granted in the same cycle.
- In-flight tracking: `inflight` (2 bits) loads RD_LAT on any grant. Otherwise it decrements while nonzero.
- WRITE:
  - upd_ready = 1 (combinational, on state only).
  - On each accepted beat, the next cycle shows:
    - we = 1;
    - both page addresses = `wr_cnt`;
    - both data outputs = `upd_data`.
  - `wr_cnt` then increments.
  - If `upd_valid` = 0, the next cycle has we = 0 and `wr_cnt` holds. Bubbles are allowed.
- `table_valid` clears on entry to WRITE and sets in DONE.
- DONE:
  - The final write (page DEPTH-1) has we = 1 in this cycle.
  - load_done = 1.
  - `lut_iter` increments, wrapping 15 -> 0.
  - upd_ready = 0.
- `load_req` while busy is ignored and sets `load_overrun`. Only `rst` clears `load_overrun`.
- Write outputs are registered. The replicates never differ.

## Timing
- Reset values:
  - State IDLE.
  - we = 0; addresses = 0; data = 0.
  - upd_ready = 0; busy = 0.
  - table_valid = 0; load_done = 0.
  - lut_iter = 0; load_overrun = 0.
  - inflight = 0; wr_cnt = 0.
  - Grants follow their equation, so they are live from the first cycle after reset.
- Load with no reads in flight: `load_req` at cycle t -> DRAIN at t+1 -> WRITE at t+2 (upd_ready = 1 first at t+2).
- Last read grant at cycle g: WRITE is entered no earlier than g+RD_LAT+2. With RD_LAT = 3, `inflight` is 3, 2, 1, 0 at g+1..g+4, so WRITE starts at g+5.
- Gapless load: 32 beats at t+2..t+33, DONE at t+34, IDLE and grants reopened at t+35. The first read after reload sees the new table.
- `rst` mid-operation, synchronous to sys_clk:
  - All reset values apply the next cycle.
  - The LUT keeps a partial table and `table_valid` = 0.
  - Grants reopen immediately.
  - The upstream producer must restart its stream.
- `load_req` in DONE counts as busy: it is ignored and sets `load_overrun`.

## Test plan
- Reset: hold `rst` 2 cycles -> every output equals its reset value. After release, rd_req_A = 1 gives rd_gnt_A = 1.
- Idle load: `load_req` at cycle 10 with entries = page index mod 8, gapless -> upd_ready first at cycle 12.
  - 32 writes with page 5 = 5 on both replicates.
  - load_done at 44, lut_iter = 1, table_valid = 1.
- Drain: rd_req_A and rd_req_B granted at cycle 10, `load_req` at 11 -> no grants from 11, WRITE entered at cycle 15.
- Bubbles: `upd_valid` toggling 1/0 -> exactly 32 we pulses, addresses 0..31 with no skips or repeats, DONE after the 32nd.
- Overrun and wrap:
  - `load_req` during WRITE -> load_overrun = 1, reload unaffected.
  - 16 completed reloads -> lut_iter returns to 0.
- Reset mid-write: `rst` after beat 12 -> next cycle we = 0, table_valid = 0, IDLE.
  - A fresh reload then writes pages 0..31 again.

Source files
------------

// File: rtl/vn_lut_update_ctrl.sv
// Reload sequencer for the symmetric VN LUT: drains in-flight VNU reads, then streams a fresh
// table into both write replicates while holding off new read grants.
module vn_lut_update_ctrl #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_data,
  output logic              upd_ready,
  input  logic              rd_req_A,
  input  logic              rd_req_B,
  output logic              rd_gnt_A,
  output logic              rd_gnt_B,
  output logic              we,
  output logic [ADDR_W-1:0] page_write_addr_replicate_0,
  output logic [ADDR_W-1:0] page_write_addr_replicate_1,
  output logic [DATA_W-1:0] lut_in_bank0_replicate_0,
  output logic [DATA_W-1:0] lut_in_bank0_replicate_1,
  output logic              write_addr_offset_replicate_0,
  output logic              write_addr_offset_replicate_1,
  output logic              busy,
  output logic              table_valid,
  output logic              load_done,
  output logic [3:0]        lut_iter,
  output logic              load_overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StWrite,
    StDone
  } state_e;

  localparam logic [1:0]        RdLatCnt = 2'(RD_LAT);
  localparam logic [ADDR_W-1:0] LastPage = ADDR_W'(DEPTH - 1);

  state_e            state;
  logic [1:0]        inflight;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              any_gnt;

  // load_req wins over reads arriving in the same cycle, so no read slips in behind a reload.
  assign rd_gnt_A  = rd_req_A & (state == StIdle) & ~load_req;
  assign rd_gnt_B  = rd_req_B & (state == StIdle) & ~load_req;
  assign any_gnt   = rd_gnt_A | rd_gnt_B;
  assign upd_ready = (state == StWrite);
  assign busy      = (state != StIdle);

  // A single write register feeds both replicates so they can never diverge.
  assign page_write_addr_replicate_0   = wr_addr;
  assign page_write_addr_replicate_1   = wr_addr;
  assign lut_in_bank0_replicate_0      = wr_data;
  assign lut_in_bank0_replicate_1      = wr_data;
  assign write_addr_offset_replicate_0 = 1'b0;
  assign write_addr_offset_replicate_1 = 1'b0;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= StIdle;
      inflight     <= 2'd0;
      wr_cnt       <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      we           <= 1'b0;
      table_valid  <= 1'b0;
      load_done    <= 1'b0;
      lut_iter     <= 4'd0;
      load_overrun <= 1'b0;
    end else begin
      we        <= 1'b0;
      load_done <= 1'b0;

      if (any_gnt) begin
        inflight <= RdLatCnt;
      end else if (inflight != 2'd0) begin
        inflight <= inflight - 2'd1;
      end

      if (load_req && (state != StIdle)) begin
        load_overrun <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (load_req) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (inflight == 2'd0) begin
            state       <= StWrite;
            table_valid <= 1'b0;
            wr_cnt      <= '0;
          end
        end
        StWrite: begin
          if (upd_valid) begin
            we      <= 1'b1;
            wr_addr <= wr_cnt;
            wr_data <= upd_data;
            wr_cnt  <= wr_cnt + ADDR_W'(1);
            if (wr_cnt == LastPage) begin
              state       <= StDone;
              load_done   <= 1'b1;
              table_valid <= 1'b1;
              lut_iter    <= lut_iter + 4'd1;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
